// File: rtl/aes_key_sched.sv
// AES-128/192/256 key expansion, one 32-bit word per cycle.
// Words are grouped four at a time into round keys with valid/ready output.
module aes_key_sched #(
    parameter int SUPPORT_192 = 1,
    parameter int RK_IDX_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [255:0]        key_in,
    input  logic [1:0]          key_mode,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [127:0]        rk_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic                rk_last,
    output logic                busy,
    output logic                mode_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [RK_IDX_W-1:0] IDX_ONE = {{(RK_IDX_W-1){1'b0}}, 1'b1};

    // FIPS-197 S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [1:0]          r_state;
    logic [1:0]          r_mode;
    logic [255:0]        r_key;
    logic [5:0]          r_i;
    logic [2:0]          r_imod;
    logic [7:0]          r_rcon;
    logic [31:0]         r_win [8];
    logic [95:0]         r_asm;
    logic [127:0]        r_rk_data;
    logic [RK_IDX_W-1:0] r_rk_idx;
    logic [RK_IDX_W-1:0] r_kcnt;
    logic                r_rk_valid;
    logic                r_rk_last;
    logic                r_mode_err;

    logic        w_legal;
    logic [2:0]  w_nk_m1;
    logic [5:0]  w_last_i;
    logic [31:0] w_old;
    logic [31:0] w_prev;
    logic [31:0] w_sub;
    logic [31:0] w_temp;
    logic [31:0] w_word;
    logic        w_from_key;
    logic        w_grp_end;
    logic        w_adv;
    logic        w_drain;
    logic [7:0]  w_xtime;

    assign w_legal = (key_mode == 2'b00) || (key_mode == 2'b10) ||
                     ((key_mode == 2'b01) && (SUPPORT_192 != 0));

    // Per-mode key length, last word index and the w[i-Nk] window tap.
    always_comb begin
        w_nk_m1  = 3'd7;
        w_last_i = 6'd59;
        w_old    = r_win[7];
        unique case (r_mode)
            2'b00: begin
                w_nk_m1  = 3'd3;
                w_last_i = 6'd43;
                w_old    = r_win[3];
            end
            2'b01: begin
                w_nk_m1  = 3'd5;
                w_last_i = 6'd51;
                w_old    = r_win[5];
            end
            default: begin
                w_nk_m1  = 3'd7;
                w_last_i = 6'd59;
                w_old    = r_win[7];
            end
        endcase
    end

    assign w_prev     = r_win[0];
    assign w_from_key = (r_i <= {3'b000, w_nk_m1});
    assign w_sub      = sub_word((r_imod == 3'd0) ?
                                 {w_prev[23:0], w_prev[31:24]} : w_prev);
    assign w_grp_end  = (r_i[1:0] == 2'b11);
    assign w_drain    = r_rk_valid && rk_ready;
    assign w_adv      = (r_state == S_RUN) &&
                        !(w_grp_end && r_rk_valid && !rk_ready);
    assign w_xtime    = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // Recurrence term applied to w[i-1] before the XOR with w[i-Nk].
    always_comb begin
        w_temp = w_prev;
        if (r_imod == 3'd0)
            w_temp = w_sub ^ {r_rcon, 24'h0};
        else if ((r_mode == 2'b10) && (r_imod == 3'd4))
            w_temp = w_sub;
    end

    assign w_word = w_from_key ? r_key[255:224] : (w_old ^ w_temp);

    // Control FSM, word counters, Rcon and round-key output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mode     <= 2'b00;
            r_key      <= '0;
            r_i        <= '0;
            r_imod     <= '0;
            r_rcon     <= '0;
            r_asm      <= '0;
            r_rk_data  <= '0;
            r_rk_idx   <= '0;
            r_kcnt     <= '0;
            r_rk_valid <= 1'b0;
            r_rk_last  <= 1'b0;
            r_mode_err <= 1'b0;
        end else begin
            r_mode_err <= 1'b0;
            if (w_drain) begin
                r_rk_valid <= 1'b0;
                r_rk_last  <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (key_valid) begin
                        if (w_legal) begin
                            r_key   <= key_in;
                            r_mode  <= key_mode;
                            r_i     <= '0;
                            r_imod  <= '0;
                            r_rcon  <= 8'h01;
                            r_kcnt  <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_mode_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_adv) begin
                        r_i    <= r_i + 6'd1;
                        r_imod <= (r_imod == w_nk_m1) ? 3'd0 : r_imod + 3'd1;
                        if (w_from_key)
                            r_key <= {r_key[223:0], 32'h0};
                        else if (r_imod == 3'd0)
                            r_rcon <= w_xtime;
                        if (w_grp_end) begin
                            r_rk_data  <= {r_asm, w_word};
                            r_rk_idx   <= r_kcnt;
                            r_kcnt     <= r_kcnt + IDX_ONE;
                            r_rk_valid <= 1'b1;
                            r_rk_last  <= (r_i == w_last_i);
                            if (r_i == w_last_i)
                                r_state <= S_DRAIN;
                        end else begin
                            r_asm <= {r_asm[63:0], w_word};
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sliding history window, r_win[0] holds the newest word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 8; j++)
                r_win[j] <= '0;
        end else if (w_adv) begin
            r_win[0] <= w_word;
            for (int j = 1; j < 8; j++)
                r_win[j] <= r_win[j-1];
        end
    end

    assign key_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rk_data   = r_rk_data;
    assign rk_idx    = r_rk_idx;
    assign rk_valid  = r_rk_valid;
    assign rk_last   = r_rk_last;
    assign mode_err  = r_mode_err;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 expansion vectors.
// Round keys are compared at the consumer handshake, sampled on negedge.
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] key_in;
    logic [1:0]   key_mode;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         busy;
    logic         mode_err;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_rk   [15];
    bit           exp_have [15];

    aes_key_sched #(.SUPPORT_192(1), .RK_IDX_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .key_mode  (key_mode),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_data   (rk_data),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_last   (rk_last),
        .busy      (busy),
        .mode_err  (mode_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int j = 0; j < 15; j++) begin
            exp_have[j] = 1'b0;
            exp_rk[j]   = '0;
        end
    endtask

    task automatic load_exp(input int k, input logic [127:0] v);
        exp_rk[k]   = v;
        exp_have[k] = 1'b1;
    endtask

    task automatic set_aes128();
        clear_exp();
        load_exp(0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
        load_exp(1,  128'ha0fafe1788542cb123a339392a6c7605);
        load_exp(2,  128'hf2c295f27a96b9435935807a7359f67f);
        load_exp(3,  128'h3d80477d4716fe3e1e237e446d7a883b);
        load_exp(4,  128'hef44a541a8525b7fb671253bdb0bad00);
        load_exp(5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc);
        load_exp(6,  128'h6d88a37a110b3efddbf98641ca0093fd);
        load_exp(7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
        load_exp(8,  128'head27321b58dbad2312bf5607f8d292f);
        load_exp(9,  128'hac7766f319fadc2128d12941575c006e);
        load_exp(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    endtask

    // Present one key for a single cycle; returns at the negedge after E0.
    task automatic send_key(input logic [255:0] k, input logic [1:0] m);
        @(negedge clk);
        chk("key_ready_before", 128'(key_ready), 128'd1);
        key_in    = k;
        key_mode  = m;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Consume nr+1 round keys, optionally with backpressure and a stray key.
    task automatic drain(input int nr, input bit bp, input bit poke);
        int k = 0;
        int cyc = 0;
        int hold = 0;
        bit stalled = 1'b0;
        logic [127:0] held = '0;
        while (k <= nr && cyc < 3000) begin
            if (poke) begin
                key_mode  = 2'b11;
                key_valid = (cyc == 10);
                if (cyc == 11) begin
                    chk("mode_err_in_run", 128'(mode_err), 128'd0);
                    chk("busy_in_run", 128'(busy), 128'd1);
                end
            end
            if (stalled) begin
                chk("stall_valid", 128'(rk_valid), 128'd1);
                chk("stall_data", rk_data, held);
            end
            if (!bp)
                rk_ready = 1'b1;
            else if (k == 3 && rk_valid && hold < 20) begin
                rk_ready = 1'b0;
                hold++;
            end else
                rk_ready = 1'($urandom_range(0, 1));
            stalled = rk_valid && !rk_ready;
            held    = rk_data;
            if (rk_valid && rk_ready) begin
                if (exp_have[k])
                    chk($sformatf("rk%0d", k), rk_data, exp_rk[k]);
                chk("rk_idx", 128'(rk_idx), 128'(k));
                chk("rk_last", 128'(rk_last), 128'(k == nr));
                if (!bp)
                    chk("latency", 128'(cyc), 128'(4 * k + 4));
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        key_valid = 1'b0;
        if (k <= nr)
            chk("timeout_keys", 128'(k), 128'(nr + 1));
        chk("key_ready_after", 128'(key_ready), 128'd1);
        chk("busy_after", 128'(busy), 128'd0);
        chk("rk_valid_after", 128'(rk_valid), 128'd0);
    endtask

    localparam logic [255:0] KEY128 =
        {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 =
        {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        int cyc;
        reset     = 1'b1;
        key_in    = '0;
        key_mode  = 2'b00;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        clear_exp();

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_rk_last", 128'(rk_last), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_mode_err", 128'(mode_err), 128'd0);
        chk("rst_rk_data", rk_data, 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd0);
        reset = 1'b0;

        // Illegal mode in IDLE.
        @(negedge clk);
        key_in    = KEY128;
        key_mode  = 2'b11;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        chk("illegal_mode_err", 128'(mode_err), 128'd1);
        chk("illegal_busy", 128'(busy), 128'd0);
        chk("illegal_key_ready", 128'(key_ready), 128'd1);
        @(negedge clk);
        chk("illegal_pulse_end", 128'(mode_err), 128'd0);
        chk("illegal_busy2", 128'(busy), 128'd0);

        // AES-128, no backpressure.
        set_aes128();
        send_key(KEY128, 2'b00);
        drain(10, 1'b0, 1'b0);

        // AES-192.
        clear_exp();
        load_exp(0,  128'h8e73b0f7da0e6452c810f32b809079e5);
        load_exp(1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        load_exp(12, 128'he98ba06f448c773c8ecc720401002202);
        send_key(KEY192, 2'b01);
        drain(12, 1'b0, 1'b0);

        // AES-256.
        clear_exp();
        load_exp(0,  128'h603deb1015ca71be2b73aef0857d7781);
        load_exp(1,  128'h1f352c073b6108d72d9810a30914dff4);
        load_exp(2,  128'h9ba354118e6925afa51a8b5f2067fcde);
        load_exp(3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a);
        load_exp(14, 128'hfe4890d1e6188d0b046df344706c631e);
        send_key(KEY256, 2'b10);
        drain(14, 1'b0, 1'b0);

        // AES-128 with backpressure and a key offered during RUN.
        set_aes128();
        send_key(KEY128, 2'b00);
        drain(10, 1'b1, 1'b1);

        // Reset in the middle of an AES-256 expansion.
        rk_ready = 1'b1;
        send_key(KEY256, 2'b10);
        cyc = 0;
        while (!(rk_valid && rk_idx == 4'd5) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_k5", 128'(rk_idx), 128'd5);
        reset = 1'b1;
        #1;
        chk("abort_rk_valid", 128'(rk_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_key_ready", 128'(key_ready), 128'd1);
        chk("abort_rk_idx", 128'(rk_idx), 128'd0);
        @(negedge clk);
        chk("abort_hold_valid", 128'(rk_valid), 128'd0);
        reset = 1'b0;

        set_aes128();
        send_key(KEY128, 2'b00);
        drain(10, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
